// File: rtl/rot_share_ctrl.sv
// Two-port arbiter and sequencer for a shared 32-bit left rotator.
// Right rotates are turned into the equivalent left amount when a request is accepted.
module rot_share_ctrl #(
  parameter int DATA_W = 32,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_data_i,
  input  logic [4:0]        req0_amt_i,
  input  logic              req0_dir_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_data_i,
  input  logic [4:0]        req1_amt_i,
  input  logic              req1_dir_i,
  output logic              o_valid,
  input  logic              o_ready_i,
  output logic [DATA_W-1:0] o_y,
  output logic              o_id,
  output logic              o_busy
);

  if (DATA_W != 32) begin : g_bad_width
    $error("rot_share_ctrl supports DATA_W = 32 only");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] opnd;
  logic [4:0]        amt_q;
  logic              id_q;
  logic              rr_last;
  logic              grant0;
  logic              grant1;
  logic [4:0]        eff0;
  logic [4:0]        eff1;
  logic [DATA_W-1:0] stg [0:5];

  // A right rotate by n is a left rotate by -n modulo 32.
  assign eff0 = req0_dir_i ? (~req0_amt_i + 5'd1) : req0_amt_i;
  assign eff1 = req1_dir_i ? (~req1_amt_i + 5'd1) : req1_amt_i;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (latch).
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && rst_ni) begin
      if (req0_valid_i && req1_valid_i) begin
        if (RR_EN && !rr_last) grant1 = 1'b1;
        else                   grant0 = 1'b1;
      end else begin
        grant0 = req0_valid_i;
        grant1 = req1_valid_i;
      end
    end
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;
  assign o_busy       = (state != IDLE);

  // Log shifter: stage i rotates left by 16 >> i when amount bit 4-i is set.
  assign stg[0] = opnd;
  for (genvar i = 0; i < 5; i++) begin : g_stage
    localparam int SH = 16 >> i;
    assign stg[i+1] = amt_q[4-i] ? {stg[i][DATA_W-1-SH:0], stg[i][DATA_W-1:DATA_W-SH]}
                                 : stg[i];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      opnd    <= '0;
      amt_q   <= '0;
      id_q    <= 1'b0;
      rr_last <= 1'b1;
      o_valid <= 1'b0;
      o_y     <= '0;
      o_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            opnd    <= grant1 ? req1_data_i : req0_data_i;
            amt_q   <= grant1 ? eff1 : eff0;
            id_q    <= grant1;
            rr_last <= grant1;
            state   <= ROT;
          end
        end
        ROT: begin
          o_y     <= stg[5];
          o_id    <= id_q;
          o_valid <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          if (o_ready_i) begin
            o_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          o_valid <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rot_share_ctrl.sv
// Scoreboard bench for rot_share_ctrl: one instance per arbitration mode, observed one at a time.
// Expected results come from a plain-arithmetic rotate model and a last-granted arbitration model.
module tb_rot_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0, dir0 = 1'b0, dir1 = 1'b0;
  logic [31:0] d0 = '0, d1 = '0;
  logic [4:0]  a0 = '0, a1 = '0;
  logic        o_ready = 1'b0;

  logic        a_r0, a_r1, a_ov, a_id, a_busy;
  logic [31:0] a_y;
  logic        b_r0, b_r1, b_ov, b_id, b_busy;
  logic [31:0] b_y;

  logic        sel = 1'b0;
  logic        r0, r1, ov, oid, busy;
  logic [31:0] y;

  always #5 clk = ~clk;

  rot_share_ctrl #(.DATA_W(32), .RR_EN(1'b1)) dut_rr (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(v0), .req0_ready_o(a_r0), .req0_data_i(d0), .req0_amt_i(a0), .req0_dir_i(dir0),
    .req1_valid_i(v1), .req1_ready_o(a_r1), .req1_data_i(d1), .req1_amt_i(a1), .req1_dir_i(dir1),
    .o_valid(a_ov), .o_ready_i(o_ready), .o_y(a_y), .o_id(a_id), .o_busy(a_busy)
  );

  rot_share_ctrl #(.DATA_W(32), .RR_EN(1'b0)) dut_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(v0), .req0_ready_o(b_r0), .req0_data_i(d0), .req0_amt_i(a0), .req0_dir_i(dir0),
    .req1_valid_i(v1), .req1_ready_o(b_r1), .req1_data_i(d1), .req1_amt_i(a1), .req1_dir_i(dir1),
    .o_valid(b_ov), .o_ready_i(o_ready), .o_y(b_y), .o_id(b_id), .o_busy(b_busy)
  );

  assign r0   = sel ? b_r0   : a_r0;
  assign r1   = sel ? b_r1   : a_r1;
  assign ov   = sel ? b_ov   : a_ov;
  assign oid  = sel ? b_id   : a_id;
  assign busy = sel ? b_busy : a_busy;
  assign y    = sel ? b_y    : a_y;

  typedef struct packed {
    logic        id;
    logic [31:0] y;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cons_mode = 1;  // 0 random, 1 always ready, 2 hold off
  bit   mon_en = 1'b0;
  bit   rr_en_m = 1'b1;
  logic rr_last_m = 1'b1;

  function automatic logic [31:0] ref_rot(input logic [31:0] x, input int n, input logic right);
    n = n % 32;
    if (n == 0) return x;
    return right ? ((x >> n) | (x << (32 - n))) : ((x << n) | (x >> (32 - n)));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (cons_mode)
      0:       o_ready = ($urandom_range(0, 3) != 0);
      1:       o_ready = 1'b1;
      default: o_ready = 1'b0;
    endcase
  end

  // Monitor: handshake rules, output stability under backpressure, scoreboard pops.
  logic        pv = 1'b0, phs = 1'b0, pid = 1'b0;
  logic [31:0] py = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || !mon_en) begin
      pv  = 1'b0;
      phs = 1'b0;
    end else begin
      check("ready_excl", 32'(r0 & r1), 0);
      if (busy) check("ready_busy", 32'({r0, r1}), 0);
      if (ov) check("valid_busy", 32'(busy), 1);
      if (ov && pv && !phs) begin
        check("hold_y", y, py);
        check("hold_id", 32'(oid), 32'(pid));
      end
      phs = ov && o_ready;
      if (phs) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got y=%0h id=%0d with nothing pending", y, oid);
        end else begin
          e = sb.pop_front();
          check("out_y", y, e.y);
          check("out_id", 32'(oid), 32'(e.id));
        end
      end
      pv  = ov;
      py  = y;
      pid = oid;
    end
  end

  task automatic drive_req(input logic pv0, input logic [31:0] pd0, input logic [4:0] pa0,
                           input logic pdir0, input logic pv1, input logic [31:0] pd1,
                           input logic [4:0] pa1, input logic pdir1);
    v0 = pv0; d0 = pd0; a0 = pa0; dir0 = pdir0;
    v1 = pv1; d1 = pd1; a1 = pa1; dir1 = pdir1;
  endtask

  task automatic drive_rand();
    int p;
    p = $urandom_range(1, 3);
    drive_req(p[0], $urandom, 5'($urandom), 1'($urandom),
              p[1], $urandom, 5'($urandom), 1'($urandom));
  endtask

  // Waits for a grant, checks it against the arbitration model and queues the expected result.
  // With post set, scrambles the request inputs while busy and checks the result latency.
  task automatic wait_accept(input int budget, input bit post);
    int   g;
    bit   got;
    exp_t e;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (r0 || r1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: no ready within %0d cycles", budget);
      v0 = 1'b0;
      v1 = 1'b0;
      return;
    end
    if (v0 && v1) g = (rr_en_m && rr_last_m == 1'b0) ? 1 : 0;
    else          g = v1 ? 1 : 0;
    check("grant", 32'({r0, r1}), (g == 1) ? 32'd1 : 32'd2);
    e.id = g[0];
    e.y  = (g == 1) ? ref_rot(d1, int'(a1), dir1) : ref_rot(d0, int'(a0), dir0);
    sb.push_back(e);
    rr_last_m = g[0];
    if (post) begin
      @(posedge clk);
      #1;
      drive_rand();
      @(posedge clk);
      #1;
      check("latency_valid", 32'(ov), 1);
      check("latency_id", 32'(oid), 32'(g));
    end
  endtask

  task automatic drain();
    v0 = 1'b0;
    v1 = 1'b0;
    cons_mode = 1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    check("drain_left", 32'(sb.size()), 0);
  endtask

  task automatic do_reset(input logic s, input bit rr);
    @(negedge clk);
    rst_n = 1'b0;
    sel = s;
    rr_en_m = rr;
    sb.delete();
    rr_last_m = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(ov), 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_ready"}, 32'({r0, r1}), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with both requests valid: no ready may leak out.
    v0 = 1'b1;
    v1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset_id", 32'(oid), 0);
    v0 = 1'b0;
    v1 = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Directed vectors.
    @(posedge clk);
    #1;
    drive_req(1'b1, 32'h8000_0001, 5'd1, 1'b0, 1'b0, '0, '0, 1'b0);
    wait_accept(10, 1'b1);
    drive_req(1'b0, '0, '0, 1'b0, 1'b1, 32'h1234_5678, 5'd4, 1'b1);
    wait_accept(10, 1'b1);
    drive_req(1'b0, '0, '0, 1'b0, 1'b1, 32'hA5A5_A5A5, 5'd0, 1'b1);
    wait_accept(10, 1'b1);
    drive_req(1'b1, 32'hDEAD_BEEF, 5'd16, 1'b1, 1'b0, '0, '0, 1'b0);
    wait_accept(10, 1'b1);

    // Round-robin alternation under continuous contention.
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b1, 32'h1, 5'd31, 1'b0, 1'b1, 32'h2, 5'd31, 1'b0);
      wait_accept(10, 1'b1);
    end

    // Random traffic with random consumer backpressure.
    cons_mode = 0;
    for (int i = 0; i < 40; i++) begin
      drive_rand();
      wait_accept(60, 1'b1);
    end
    drain();

    // Long backpressure in DONE, then the pending request goes in right after release.
    @(negedge clk);
    cons_mode = 2;
    @(posedge clk);
    #1;
    drive_req(1'b1, 32'hCAFE_F00D, 5'd7, 1'b0, 1'b1, 32'h0F0F_1234, 5'd9, 1'b1);
    wait_accept(10, 1'b1);
    drive_rand();
    repeat (10) @(posedge clk);
    #1;
    check("bp_valid", 32'(ov), 1);
    @(negedge clk);
    cons_mode = 1;
    wait_accept(2, 1'b1);
    drain();

    // Reset during ROT.
    do_reset(1'b0, 1'b1);
    cons_mode = 2;
    @(posedge clk);
    #1;
    drive_req(1'b1, 32'h1357_9BDF, 5'd5, 1'b0, 1'b0, '0, '0, 1'b0);
    wait_accept(10, 1'b0);
    @(posedge clk);
    #1;
    v0 = 1'b0;
    check("pre_rot_busy", 32'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_rot");
    sb.delete();
    rr_last_m = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during DONE with a nonzero result on the output.
    @(posedge clk);
    #1;
    drive_req(1'b0, '0, '0, 1'b0, 1'b1, 32'h1234_5679, 5'd3, 1'b0);
    wait_accept(10, 1'b0);
    @(posedge clk);
    #1;
    v1 = 1'b0;
    @(posedge clk);
    #1;
    check("pre_done_valid", 32'(ov), 1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_done");
    sb.delete();
    rr_last_m = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    cons_mode = 1;

    // First contention after reset goes to port 0.
    @(posedge clk);
    #1;
    drive_req(1'b1, 32'h0000_00F0, 5'd4, 1'b1, 1'b1, 32'h0000_0F00, 5'd4, 1'b0);
    wait_accept(10, 1'b1);
    drain();

    // Fixed-priority instance: port 0 always wins contention.
    do_reset(1'b1, 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b1, 32'h1, 5'd31, 1'b0, 1'b1, 32'h2, 5'd31, 1'b0);
      wait_accept(10, 1'b1);
    end
    cons_mode = 0;
    for (int i = 0; i < 20; i++) begin
      drive_rand();
      wait_accept(60, 1'b1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
